// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared types and constants for the USB receive bit decoder
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        EOP_SE0 = 2'd2,
        ERROR   = 2'd3
    } rx_state_t;

    localparam int STUFF_LIMIT   = 6;
    localparam int BITS_PER_BYTE = 8;

    function automatic logic is_se0(input logic dp, input logic dm);
        return !dp && !dm;
    endfunction

    function automatic logic is_j(input logic dp, input logic dm);
        return dp && !dm;
    endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// rtl/usb_bit_timer.sv - resyncable bit-period timer producing a mid-bit sample strobe
module usb_bit_timer #(
    parameter int CLKS_PER_BIT  = 8,
    parameter int SAMPLE_OFFSET = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic run,
    input  logic restart,
    output logic sample
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Held at zero while not receiving so the first bit after SOP lines up.
    always_comb begin
        cnt_d = cnt_q;
        if (!run || restart) begin
            cnt_d = '0;
        end else if (cnt_q == TW'(CLKS_PER_BIT - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sample = run && (cnt_q == TW'(SAMPLE_OFFSET));

endmodule

// File: rtl/usb_rx_bit_decoder.sv
// rtl/usb_rx_bit_decoder.sv - NRZI decode, bit unstuffing and EOP detection for USB FS receive
module usb_rx_bit_decoder
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 8,
    parameter int SAMPLE_OFFSET = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus,
    input  logic d_minus,
    input  logic rx_enable,
    output logic shift_enable,
    output logic serial_in,
    output logic byte_received,
    output logic eop,
    output logic stuff_error,
    output logic rcving
);
    localparam int BCW = $clog2(BITS_PER_BYTE);
    localparam int OCW = $clog2(STUFF_LIMIT + 1);

    rx_state_t state_q, state_d;
    logic           dp_last_q, dp_last_d;
    logic           prev_q, prev_d;
    logic [OCW-1:0] ones_q, ones_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic           se0_seen_q, se0_seen_d;
    logic           shift_enable_q, shift_enable_d;
    logic           serial_in_q, serial_in_d;
    logic           byte_received_q, byte_received_d;
    logic           eop_q, eop_d;
    logic           stuff_error_q, stuff_error_d;
    logic           rcving_q, rcving_d;

    logic sample;
    logic timer_run;
    logic timer_restart;
    logic line_se0;
    logic line_j;
    logic decoded;

    assign line_se0      = is_se0(d_plus, d_minus);
    assign line_j        = is_j(d_plus, d_minus);
    assign decoded       = (d_plus == prev_q);
    assign timer_run     = (state_q != IDLE);
    assign timer_restart = (d_plus != dp_last_q);

    usb_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SAMPLE_OFFSET(SAMPLE_OFFSET)
    ) u_bit_timer (
        .clk    (clk),
        .n_rst  (n_rst),
        .run    (timer_run),
        .restart(timer_restart),
        .sample (sample)
    );

    always_comb begin
        state_d         = state_q;
        dp_last_d       = d_plus;
        prev_d          = prev_q;
        ones_d          = ones_q;
        bit_cnt_d       = bit_cnt_q;
        se0_seen_d      = se0_seen_q;
        shift_enable_d  = 1'b0;
        serial_in_d     = serial_in_q;
        byte_received_d = 1'b0;
        eop_d           = 1'b0;
        stuff_error_d   = 1'b0;

        // Byte accounting follows the registered strobe, so byte_received trails it by one.
        if (shift_enable_q) begin
            byte_received_d = (bit_cnt_q == BCW'(BITS_PER_BYTE - 1));
            if (bit_cnt_q == BCW'(BITS_PER_BYTE - 1)) begin
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                prev_d     = 1'b1;
                ones_d     = '0;
                bit_cnt_d  = '0;
                se0_seen_d = 1'b0;
                if (rx_enable && dp_last_q && !d_plus) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (sample) begin
                    if (line_se0) begin
                        state_d = EOP_SE0;
                    end else begin
                        prev_d = d_plus;
                        if (ones_q == OCW'(STUFF_LIMIT)) begin
                            ones_d = '0;
                            if (decoded) begin
                                stuff_error_d = 1'b1;
                                state_d       = ERROR;
                            end
                        end else begin
                            shift_enable_d = 1'b1;
                            serial_in_d    = decoded;
                            ones_d         = decoded ? ones_q + 1'b1 : '0;
                        end
                    end
                end
            end
            EOP_SE0: begin
                if (sample && line_j) begin
                    state_d = IDLE;
                    eop_d   = 1'b1;
                end
            end
            ERROR: begin
                if (sample) begin
                    if (line_se0) begin
                        se0_seen_d = 1'b1;
                    end else if (line_j && se0_seen_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!rx_enable) begin
            state_d         = IDLE;
            shift_enable_d  = 1'b0;
            byte_received_d = 1'b0;
            eop_d           = 1'b0;
            stuff_error_d   = 1'b0;
        end

        rcving_d = (state_d != IDLE);
    end

    // dp_last resets low so a line already at K after reset is not taken as SOP.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= IDLE;
            dp_last_q       <= 1'b0;
            prev_q          <= 1'b1;
            ones_q          <= '0;
            bit_cnt_q       <= '0;
            se0_seen_q      <= 1'b0;
            shift_enable_q  <= 1'b0;
            serial_in_q     <= 1'b1;
            byte_received_q <= 1'b0;
            eop_q           <= 1'b0;
            stuff_error_q   <= 1'b0;
            rcving_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            dp_last_q       <= dp_last_d;
            prev_q          <= prev_d;
            ones_q          <= ones_d;
            bit_cnt_q       <= bit_cnt_d;
            se0_seen_q      <= se0_seen_d;
            shift_enable_q  <= shift_enable_d;
            serial_in_q     <= serial_in_d;
            byte_received_q <= byte_received_d;
            eop_q           <= eop_d;
            stuff_error_q   <= stuff_error_d;
            rcving_q        <= rcving_d;
        end
    end

    assign shift_enable  = shift_enable_q;
    assign serial_in     = serial_in_q;
    assign byte_received = byte_received_q;
    assign eop           = eop_q;
    assign stuff_error   = stuff_error_q;
    assign rcving        = rcving_q;

endmodule

// File: doc/usb_rx_bit_decoder.md
USB_RX_BIT_DECODER -- requirements
Module: usb_rx_bit_decoder

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, clk cycles per USB bit (full-speed, clk = 96 MHz).
REQ-002 SHALL have parameter SAMPLE_OFFSET, default 3, cycles after bit-timer restart at which the line is sampled (mid-bit).
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 d_plus  input  1  D+ line, already two-flop synchronized.
REQ-006 d_minus  input  1  D- line, already two-flop synchronized.
REQ-007 rx_enable  input  1  high = decoding permitted; low forces IDLE.
REQ-008 shift_enable  output  1  one-cycle strobe: serial_in is a valid decoded, unstuffed bit for the downstream serial-to-parallel register.
REQ-009 serial_in  output  1  NRZI-decoded data bit; valid when shift_enable high.
REQ-010 byte_received  output  1  one-cycle pulse, one cycle after the 8th shift_enable of a byte.
REQ-011 eop  output  1  one-cycle pulse on end-of-packet completion.
REQ-012 stuff_error  output  1  one-cycle pulse on bit-stuff violation.
REQ-013 rcving  output  1  high from SOP detection until return to IDLE.

Function
REQ-014 SHALL implement states IDLE, ACTIVE, EOP_SE0, ERROR.
REQ-015 IDLE -> ACTIVE when rx_enable=1 and d_plus falls (J->K); bit timer cleared that cycle; rcving set next cycle.
REQ-016 Bit timer SHALL count 0..CLKS_PER_BIT-1 and wrap; on any d_plus transition in ACTIVE it SHALL restart at 0 (resync).
REQ-017 Sample event SHALL occur when timer == SAMPLE_OFFSET; exactly one per bit period absent resync.
REQ-018 At sample, if d_plus=0 and d_minus=0 (SE0): ACTIVE -> EOP_SE0, no shift_enable.
REQ-019 Otherwise decoded bit = 1 if d_plus equals previous sampled d_plus, else 0; previous-sample register SHALL be 1 on entry to IDLE.
REQ-020 Ones counter SHALL count consecutive decoded 1s, clear on any 0 or IDLE.
REQ-021 Bit following six consecutive 1s SHALL be dropped (no shift_enable) if 0; if 1, stuff_error pulses and state -> ERROR.
REQ-022 shift_enable and serial_in SHALL assert registered, the cycle after the sample event.
REQ-023 Bit counter 0..7 SHALL advance per shift_enable, wrap 7->0, clear in IDLE; byte_received pulses the cycle after the shift_enable that wraps it.
REQ-024 EOP_SE0 -> IDLE on first sample with d_plus=1, d_minus=0 (J); eop pulses that cycle; rcving clears next cycle.
REQ-025 ERROR SHALL hold until a J is sampled after SE0 (full EOP), then -> IDLE without eop pulse.
REQ-026 rx_enable=0 in any state SHALL force IDLE next cycle, cancel pending strobes, no eop pulse.
REQ-027 SE0 sampled on the stuff-bit slot SHALL be treated as EOP, not stuff error.
REQ-028 Partial byte at EOP SHALL not produce byte_received.

Reset
REQ-029 On n_rst low: state IDLE, timer 0, ones/bit counters 0, previous sample 1.
REQ-030 Output reset values: shift_enable 0, serial_in 1, byte_received 0, eop 0, stuff_error 0, rcving 0.
REQ-031 Reset mid-packet SHALL abort immediately; no strobe after release until a new J->K.

Structure
REQ-032 Package usb_rx_pkg SHALL hold state enum rx_state_t, STUFF_LIMIT=6, BITS_PER_BYTE=8.
REQ-033 Sub-module usb_bit_timer SHALL hold the resyncable timer and produce the sample strobe; all else in one registered FSM.

Verification
REQ-034 Idle J, then SYNC KJKJKJKK at 8 clk/bit -> 8 shift_enables, bits 0,0,0,0,0,0,0,1, byte_received once.
REQ-035 Data 0xFF after SYNC with stuffed 0 after sixth 1 -> 8 shift_enables, no strobe for stuffed bit, byte_received once.
REQ-036 Seven consecutive 1s (no stuff) -> stuff_error pulse, no further shift_enable, no eop after SE0,SE0,J.
REQ-037 Byte then SE0,SE0,J -> eop pulse once, rcving low next cycle, no extra byte_received.
REQ-038 Bit edges jittered ±1 clk across 16 bits -> all bits decoded correctly via resync.
REQ-039 n_rst asserted mid-byte, rx_enable dropped mid-byte -> outputs at reset values / IDLE, no eop.
